// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard control bundle.
// Slave side is the hazard controller; master side drives decode info.
interface pipe_hazard_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int FW     = 2,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [ADDR_W-1:0] id_src0;
   logic [ADDR_W-1:0] id_src1;
   logic              id_src0_en;
   logic              id_src1_en;
   logic [ADDR_W-1:0] id_dst;
   logic              id_we;
   logic              id_load;
   logic              id_hlt;
   logic              ex_kill;
   logic              ex_we_cancel;
   logic              stall_id;
   logic [FW-1:0]     fwd0;
   logic [FW-1:0]     fwd1;
   logic              halted;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_src0, id_src1, id_src0_en, id_src1_en,
      output id_dst, id_we, id_load, id_hlt, ex_kill, ex_we_cancel,
      input  stall_id, fwd0, fwd1, halted, stall_cnt
   );

   modport slave (
      input  id_valid, id_src0, id_src1, id_src0_en, id_src1_en,
      input  id_dst, id_we, id_load, id_hlt, ex_kill, ex_we_cancel,
      output stall_id, fwd0, fwd1, halted, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Post-decode hazard tracker: forwarding selects, load-use stall,
// halt drain and saturating stall counter.
module pipe_hazard_ctrl #(
   parameter int P_STAGES = 3,
   parameter int ADDR_W   = 4,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input logic clk,
   input logic rst_n,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int FW = $clog2(P_STAGES + 1);

   logic [P_STAGES:1] v_q;
   logic [P_STAGES:1] we_q;
   logic [P_STAGES:1] ld_q;
   logic [P_STAGES:1] hlt_q;
   logic [ADDR_W-1:0] dst_q [1:P_STAGES];

   logic             halt_pend_q;
   logic             halted_q;
   logic [CNT_W-1:0] cnt_q;

   logic [FW-1:0] fwd0;
   logic [FW-1:0] fwd1;
   logic          lu0;
   logic          lu1;
   logic          stall;
   logic          issue;
   logic          retire;

   // Youngest matching stage wins: scan oldest to youngest, last hit sticks.
   always_comb begin
      fwd0 = '0;
      fwd1 = '0;
      lu0  = 1'b0;
      lu1  = 1'b0;
      for (int k = P_STAGES; k >= 1; k--) begin
         if (bus.id_src0_en && v_q[k] && we_q[k] &&
             dst_q[k] == bus.id_src0 && bus.id_src0 != '0) begin
            fwd0 = FW'(k);
            lu0  = (k <= LOAD_LAT) && ld_q[k];
         end
         if (bus.id_src1_en && v_q[k] && we_q[k] &&
             dst_q[k] == bus.id_src1 && bus.id_src1 != '0) begin
            fwd1 = FW'(k);
            lu1  = (k <= LOAD_LAT) && ld_q[k];
         end
      end
   end

   assign stall  = bus.id_valid & (lu0 | lu1 | halt_pend_q | halted_q);
   assign issue  = bus.id_valid & ~stall & ~bus.ex_kill;
   assign retire = v_q[P_STAGES] & hlt_q[P_STAGES];

   assign bus.stall_id  = stall;
   assign bus.fwd0      = fwd0;
   assign bus.fwd1      = fwd1;
   assign bus.halted    = halted_q;
   assign bus.stall_cnt = cnt_q;

   // Stage tracker: always shifts, bubble enters when nothing issues.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         we_q  <= '0;
         ld_q  <= '0;
         hlt_q <= '0;
         for (int k = 1; k <= P_STAGES; k++) begin
            dst_q[k] <= '0;
         end
      end else begin
         v_q[1]   <= issue;
         we_q[1]  <= issue & bus.id_we;
         ld_q[1]  <= issue & bus.id_load;
         hlt_q[1] <= issue & bus.id_hlt;
         dst_q[1] <= issue ? bus.id_dst : '0;
         v_q[2]   <= v_q[1];
         we_q[2]  <= we_q[1] & ~bus.ex_we_cancel;
         ld_q[2]  <= ld_q[1];
         hlt_q[2] <= hlt_q[1];
         dst_q[2] <= dst_q[1];
         for (int k = 3; k <= P_STAGES; k++) begin
            v_q[k]   <= v_q[k-1];
            we_q[k]  <= we_q[k-1];
            ld_q[k]  <= ld_q[k-1];
            hlt_q[k] <= hlt_q[k-1];
            dst_q[k] <= dst_q[k-1];
         end
      end
   end

   // Halt drain: pending from issue until the halt reaches the last stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt_pend_q <= 1'b0;
         halted_q    <= 1'b0;
      end else if (retire) begin
         halt_pend_q <= 1'b0;
         halted_q    <= 1'b1;
      end else if (issue && bus.id_hlt) begin
         halt_pend_q <= 1'b1;
      end
   end

   // Stall counter saturates and freezes once the core has halted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (stall && !halted_q && !(&cnt_q)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic
// against a queue-based model of in-flight instructions.
module tb_pipe_hazard_ctrl;
   localparam int P_STAGES = 3;
   localparam int ADDR_W   = 4;
   localparam int LOAD_LAT = 1;
   localparam int CNT_W    = 4;
   localparam int FW       = 2;
   localparam int CMAX     = 15;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   pipe_hazard_ctrl_if #(
      .ADDR_W(ADDR_W), .FW(FW), .CNT_W(CNT_W)
   ) bus ();

   pipe_hazard_ctrl #(
      .P_STAGES(P_STAGES), .ADDR_W(ADDR_W),
      .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit v;
      bit we;
      bit ld;
      bit hlt;
      int dst;
   } rec_t;

   rec_t hist[$];
   bit   m_pend;
   bit   m_halted;
   int   m_cnt;

   function automatic void model_clear();
      rec_t b;
      b.v = 0; b.we = 0; b.ld = 0; b.hlt = 0; b.dst = 0;
      hist.delete();
      for (int i = 0; i < P_STAGES; i++) hist.push_back(b);
      m_pend   = 0;
      m_halted = 0;
      m_cnt    = 0;
   endfunction

   function automatic int m_fwd(int src, bit en);
      if (!en || src == 0) return 0;
      for (int i = 0; i < hist.size(); i++)
         if (hist[i].v && hist[i].we && hist[i].dst == src) return i + 1;
      return 0;
   endfunction

   function automatic bit m_lu(int src, bit en);
      int k;
      k = m_fwd(src, en);
      if (k == 0 || k > LOAD_LAT) return 0;
      return hist[k-1].ld;
   endfunction

   function automatic bit m_stall();
      bit lu;
      lu = m_lu(int'(bus.id_src0), bus.id_src0_en) ||
           m_lu(int'(bus.id_src1), bus.id_src1_en);
      return bus.id_valid && (lu || m_pend || m_halted);
   endfunction

   function automatic void model_tick();
      bit   st;
      bit   iss;
      bit   ret;
      rec_t r;
      st  = m_stall();
      iss = bus.id_valid && !st && !bus.ex_kill;
      ret = hist[P_STAGES-1].v && hist[P_STAGES-1].hlt;
      if (st && !m_halted && m_cnt != CMAX) m_cnt++;
      if (ret) begin
         m_halted = 1;
         m_pend   = 0;
      end else if (iss && bus.id_hlt) begin
         m_pend = 1;
      end
      if (bus.ex_we_cancel) hist[0].we = 0;
      r.v   = iss;
      r.we  = iss && bus.id_we;
      r.ld  = iss && bus.id_load;
      r.hlt = iss && bus.id_hlt;
      r.dst = iss ? int'(bus.id_dst) : 0;
      hist.push_front(r);
      void'(hist.pop_back());
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("stall_id", 32'(bus.stall_id), 32'(m_stall()));
      chk("fwd0", 32'(bus.fwd0),
          32'(m_fwd(int'(bus.id_src0), bus.id_src0_en)));
      chk("fwd1", 32'(bus.fwd1),
          32'(m_fwd(int'(bus.id_src1), bus.id_src1_en)));
      chk("halted", 32'(bus.halted), 32'(m_halted));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
   endtask

   task automatic settle();
      #2;
      check_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic idle();
      bus.id_valid     = 0;
      bus.id_src0      = '0;
      bus.id_src1      = '0;
      bus.id_src0_en   = 0;
      bus.id_src1_en   = 0;
      bus.id_dst       = '0;
      bus.id_we        = 0;
      bus.id_load      = 0;
      bus.id_hlt       = 0;
      bus.ex_kill      = 0;
      bus.ex_we_cancel = 0;
   endtask

   task automatic set_id(input bit vld, input int s0, input bit s0e,
                         input int s1, input bit s1e, input int dst,
                         input bit we, input bit ld, input bit hlt);
      bus.id_valid   = vld;
      bus.id_src0    = ADDR_W'(s0);
      bus.id_src0_en = s0e;
      bus.id_src1    = ADDR_W'(s1);
      bus.id_src1_en = s1e;
      bus.id_dst     = ADDR_W'(dst);
      bus.id_we      = we;
      bus.id_load    = ld;
      bus.id_hlt     = hlt;
   endtask

   task automatic do_reset();
      rst_n = 0;
      model_clear();
      settle();
      chk("rst_stall", 32'(bus.stall_id), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      chk("rst_cnt", 32'(bus.stall_cnt), 0);
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 0;
      idle();
      model_clear();
      set_id(1, 1, 1, 1, 1, 1, 1, 0, 0);
      #3;
      check_all();
      chk("rst_fwd0", 32'(bus.fwd0), 0);
      chk("rst_fwd1", 32'(bus.fwd1), 0);
      chk("rst_stall", 32'(bus.stall_id), 0);
      chk("rst_cnt", 32'(bus.stall_cnt), 0);
      @(posedge clk);
      #1;
      rst_n = 1;

      // ALU chain, first issue right after release
      set_id(1, 0, 0, 0, 0, 1, 1, 0, 0);
      settle(); tick();
      set_id(1, 1, 1, 0, 0, 2, 1, 0, 0);
      settle();
      chk("alu_fwd0_k1", 32'(bus.fwd0), 1);
      chk("alu_nostall", 32'(bus.stall_id), 0);
      tick();
      set_id(1, 1, 1, 0, 0, 3, 1, 0, 0);
      settle();
      chk("alu_fwd0_k2", 32'(bus.fwd0), 2);
      tick();

      // Load-use
      do_reset();
      set_id(1, 0, 0, 0, 0, 4, 1, 1, 0);
      settle(); tick();
      set_id(1, 4, 1, 0, 0, 5, 1, 0, 0);
      settle();
      chk("lu_stall", 32'(bus.stall_id), 1);
      tick();
      settle();
      chk("lu_release", 32'(bus.stall_id), 0);
      chk("lu_fwd0", 32'(bus.fwd0), 2);
      chk("lu_cnt", 32'(bus.stall_cnt), 1);
      tick();

      // Youngest wins, R0 never matches
      do_reset();
      set_id(1, 0, 0, 0, 0, 6, 1, 0, 0);
      settle(); tick();
      set_id(1, 0, 0, 0, 0, 8, 1, 0, 0);
      settle(); tick();
      set_id(1, 0, 0, 0, 0, 6, 1, 0, 0);
      settle(); tick();
      set_id(1, 0, 0, 6, 1, 0, 1, 0, 0);
      settle();
      chk("young_fwd1", 32'(bus.fwd1), 1);
      tick();
      set_id(1, 0, 1, 0, 1, 9, 1, 0, 0);
      settle();
      chk("r0_fwd0", 32'(bus.fwd0), 0);
      chk("r0_fwd1", 32'(bus.fwd1), 0);
      tick();

      // Conditional write cancel
      do_reset();
      set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
      settle(); tick();
      idle();
      bus.ex_we_cancel = 1;
      settle(); tick();
      bus.ex_we_cancel = 0;
      set_id(1, 7, 1, 7, 1, 10, 1, 0, 0);
      settle();
      chk("cancel_fwd0", 32'(bus.fwd0), 0);
      chk("cancel_fwd1", 32'(bus.fwd1), 0);
      tick();

      // Halt drain
      do_reset();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
      settle(); tick();
      set_id(1, 0, 0, 0, 0, 11, 1, 0, 0);
      for (int i = 1; i <= P_STAGES; i++) begin
         settle();
         chk("halt_stall", 32'(bus.stall_id), 1);
         chk("halt_early", 32'(bus.halted), 0);
         tick();
      end
      settle();
      chk("halted", 32'(bus.halted), 1);
      chk("halt_cnt", 32'(bus.stall_cnt), P_STAGES);
      tick();
      settle();
      chk("halt_cnt_held", 32'(bus.stall_cnt), P_STAGES);
      tick();

      // Halt squashed by kill
      do_reset();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
      bus.ex_kill = 1;
      settle(); tick();
      bus.ex_kill = 0;
      set_id(1, 0, 0, 0, 0, 12, 1, 0, 0);
      repeat (5) begin settle(); tick(); end
      settle();
      chk("kill_halted", 32'(bus.halted), 0);
      chk("kill_stall", 32'(bus.stall_id), 0);
      tick();

      // Reset mid-drain
      do_reset();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
      settle(); tick();
      set_id(1, 0, 0, 0, 0, 13, 1, 0, 0);
      settle();
      chk("drain_stall", 32'(bus.stall_id), 1);
      do_reset();
      idle();
      repeat (4) begin settle(); tick(); end
      settle();
      chk("drain_halted", 32'(bus.halted), 0);
      chk("drain_cnt", 32'(bus.stall_cnt), 0);
      tick();

      // Saturation: 20 load-use stalls
      do_reset();
      repeat (20) begin
         set_id(1, 0, 0, 0, 0, 4, 1, 1, 0);
         settle(); tick();
         set_id(1, 0, 0, 4, 1, 5, 1, 0, 0);
         settle(); tick();
         settle(); tick();
      end
      settle();
      chk("sat_cnt", 32'(bus.stall_cnt), CMAX);
      tick();

      // Random traffic
      do_reset();
      for (int c = 0; c < 600; c++) begin
         set_id($urandom_range(0, 3) != 0,
                int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
         bus.ex_kill      = $urandom_range(0, 7) == 0;
         bus.ex_we_cancel = $urandom_range(0, 3) == 0;
         settle();
         tick();
         if (m_halted && $urandom_range(0, 5) == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
